// File: rtl/dcmi_dma_wr.sv
// dcmi_dma_wr: pixel-to-memory write engine for the DCMI capture path (hclk domain).
// Packs 8..14-bit pixels into 32-bit words, buffers them in a small word FIFO and
// writes them out through a request/acknowledge RAM port.
//
// Ports
//   hclk, rst            clock (rising edge), asynchronous active-high reset
//   cfg_en               engine enable; dropping it aborts the engine
//   cfg_width            00/01/10/11 = 8/10/12/14-bit pixels
//   cfg_circ             1: wrap to cfg_saddr when cfg_len words are written; 0: stop
//   cfg_saddr, cfg_len   start byte address (bits [1:0] ignored), words per buffer
//   frm_start, frm_end   one-cycle frame strobes
//   pix_vld, pix_data    pixel stream
//   ram_wr_req/ack       write handshake; ram_waddr / ram_wdata carry the word
//   busy                 engine not in IDLE
//   frm_done, len_done   one-cycle status pulses
//   ovf_irq              one-cycle pulse when a packed word was dropped (FIFO full)
//   dbg_state            current FSM state, for observation only
//
// Handshake: ram_wr_req is the valid; ram_wr_ack is the ready. A word is transferred
// on every rising edge where req && ack. While req=1 && ack=0 the address and data are
// held stable and req is not withdrawn (only an asynchronous reset drops it).
module dcmi_dma_wr #(
  parameter int PIX_W      = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 18
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_width,
  input  logic              cfg_circ,
  input  logic [ADDR_W-1:0] cfg_saddr,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              frm_start,
  input  logic              frm_end,
  input  logic              pix_vld,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              ram_wr_req,
  input  logic              ram_wr_ack,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic              busy,
  output logic              frm_done,
  output logic              len_done,
  output logic              ovf_irq,
  output logic [1:0]        dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_CAPTURE  = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         width_q, width_d;
  logic               circ_q, circ_d;
  logic [ADDR_W-1:0]  saddr_q, saddr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic               stop_q, stop_d;
  logic [31:0]        pack_q, pack_d;
  logic [1:0]         pcnt_q, pcnt_d;
  logic               pvld_q, pvld_d;
  logic [31:0]        pdata_q, pdata_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               frm_done_q, frm_done_d;
  logic               len_done_q, len_done_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        mem [FIFO_DEPTH];

  logic [15:0]        pix_mask, pix16;
  logic [31:0]        pack_ins;
  logic               pix_last;
  logic               pix_take;
  logic               wr_ack;
  logic               abort, abort_go;
  logic               fifo_clr;
  logic               push, push_ok, full;
  logic [LEN_W-1:0]   wcnt_inc;

  // Request is simply "FIFO holds a word"; once the length limit stops the frame,
  // nothing more is written.
  assign ram_wr_req = (cnt_q != '0) && !stop_q;
  assign ram_wdata  = ram_wr_req ? mem[rd_ptr_q] : 32'd0;
  assign ram_waddr  = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign frm_done   = frm_done_q;
  assign len_done   = len_done_q;
  assign ovf_irq    = ovf_q;
  assign dbg_state  = state_q;

  assign wr_ack   = ram_wr_req && ram_wr_ack;
  assign abort    = !cfg_en && (state_q != S_IDLE);
  // An outstanding request must complete before the abort takes effect.
  assign abort_go = abort && (!ram_wr_req || ram_wr_ack);
  assign pix_take = (state_q == S_CAPTURE) && pix_vld && !stop_q && !abort;
  assign wcnt_inc = wcnt_q + LEN_W'(1);

  // Pixel masking and insertion into the packing register.
  always_comb begin
    case (width_q)
      2'b00:   pix_mask = 16'h00FF;
      2'b01:   pix_mask = 16'h03FF;
      2'b10:   pix_mask = 16'h0FFF;
      default: pix_mask = 16'h3FFF;
    endcase
    pix16    = 16'(pix_data) & pix_mask;
    pack_ins = pack_q;
    if (width_q == 2'b00) begin
      pack_ins[{pcnt_q, 3'b000} +: 8] = pix16[7:0];
      pix_last = (pcnt_q == 2'd3);
    end else begin
      pack_ins[{pcnt_q[0], 4'b0000} +: 16] = pix16;
      pix_last = pcnt_q[0];
    end
  end

  // FSM next-state, packer, address/length bookkeeping.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    circ_d     = circ_q;
    saddr_d    = saddr_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    stop_d     = stop_q;
    pack_d     = pack_q;
    pcnt_d     = pcnt_q;
    pvld_d     = 1'b0;
    pdata_d    = pdata_q;
    frm_done_d = 1'b0;
    len_done_d = 1'b0;
    fifo_clr   = stop_q;

    if (pix_take) begin
      if (pix_last) begin
        pvld_d  = 1'b1;
        pdata_d = pack_ins;
        pack_d  = 32'd0;
        pcnt_d  = 2'd0;
      end else begin
        pack_d  = pack_ins;
        pcnt_d  = pcnt_q + 2'd1;
      end
    end

    if (wr_ack) begin
      addr_d = addr_q + ADDR_W'(4);
      wcnt_d = wcnt_inc;
      if (wcnt_inc == len_q) begin
        len_done_d = 1'b1;
        if (circ_q) begin
          addr_d = saddr_q;
          wcnt_d = '0;
        end else begin
          stop_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_en) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (frm_start && cfg_en) begin
          width_d = cfg_width;
          circ_d  = cfg_circ;
          saddr_d = cfg_saddr & ~ADDR_W'(3);
          len_d   = cfg_len;
          addr_d  = cfg_saddr & ~ADDR_W'(3);
          wcnt_d  = '0;
          pack_d  = 32'd0;
          pcnt_d  = 2'd0;
          stop_d  = (cfg_len == '0);
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (frm_end && !abort) begin
          // A partial word (including a pixel taken this cycle) leaves zero-padded;
          // unused lanes of the packer are already zero.
          if (!pvld_d && (pcnt_d != 2'd0) && !stop_q) begin
            pvld_d  = 1'b1;
            pdata_d = pack_d;
          end
          pack_d  = 32'd0;
          pcnt_d  = 2'd0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!pvld_q && (cnt_q == '0)) begin
          frm_done_d = 1'b1;
          stop_d     = 1'b0;
          state_d    = cfg_en ? S_WAIT_SOF : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_go) begin
      state_d    = S_IDLE;
      fifo_clr   = 1'b1;
      pack_d     = 32'd0;
      pcnt_d     = 2'd0;
      pvld_d     = 1'b0;
      stop_d     = 1'b0;
      frm_done_d = 1'b0;
    end
  end

  // Word FIFO bookkeeping. A push into a full FIFO still succeeds when a pop
  // happens in the same cycle; otherwise the word is dropped and flagged.
  always_comb begin
    push     = pvld_q && !stop_q;
    full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    push_ok  = push && (!full || wr_ack) && !fifo_clr;
    ovf_d    = push && full && !wr_ack && !fifo_clr;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_ack)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push_ok, wr_ack})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (push_ok) mem[wr_ptr_q] <= pdata_q;
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      width_q    <= 2'd0;
      circ_q     <= 1'b0;
      saddr_q    <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wcnt_q     <= '0;
      stop_q     <= 1'b0;
      pack_q     <= 32'd0;
      pcnt_q     <= 2'd0;
      pvld_q     <= 1'b0;
      pdata_q    <= 32'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      frm_done_q <= 1'b0;
      len_done_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      circ_q     <= circ_d;
      saddr_q    <= saddr_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      stop_q     <= stop_d;
      pack_q     <= pack_d;
      pcnt_q     <= pcnt_d;
      pvld_q     <= pvld_d;
      pdata_q    <= pdata_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      frm_done_q <= frm_done_d;
      len_done_q <= len_done_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
